// File: rtl/spi_cs_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : spi_cs_sequencer_if
// Host byte stream, SPI-master byte handshake and chip select of the sequencer.
// Rev    : 1.0
// ============================================================================
interface spi_cs_sequencer_if #(
  parameter int CW = 3
);
  logic [CW-1:0] i_TX_Count;
  logic [7:0]    i_TX_Byte;
  logic          i_TX_DV;
  logic          o_TX_Ready;
  logic          o_RX_DV;
  logic [7:0]    o_RX_Byte;
  logic [CW-1:0] o_RX_Count;
  logic [7:0]    o_M_TX_Byte;
  logic          o_M_TX_DV;
  logic          i_M_TX_Ready;
  logic          i_M_RX_DV;
  logic [7:0]    i_M_RX_Byte;
  logic          o_SPI_CS_n;

  modport slave (
    input  i_TX_Count, i_TX_Byte, i_TX_DV, i_M_TX_Ready, i_M_RX_DV, i_M_RX_Byte,
    output o_TX_Ready, o_RX_DV, o_RX_Byte, o_RX_Count, o_M_TX_Byte, o_M_TX_DV,
           o_SPI_CS_n
  );

  modport master (
    output i_TX_Count, i_TX_Byte, i_TX_DV, i_M_TX_Ready, i_M_RX_DV, i_M_RX_Byte,
    input  o_TX_Ready, o_RX_DV, o_RX_Byte, o_RX_Count, o_M_TX_Byte, o_M_TX_DV,
           o_SPI_CS_n
  );
endinterface
`default_nettype wire

// File: rtl/spi_cs_sequencer.sv
`default_nettype none
// ============================================================================
// Module : spi_cs_sequencer
// Multi-byte SPI burst sequencer owning CS_n lead time and inactive gap.
// Rev    : 1.0
// ============================================================================
module spi_cs_sequencer #(
  parameter int MAX_BYTES_PER_CS = 4,
  parameter int CS_LEAD_CLKS     = 2,
  parameter int CS_INACTIVE_CLKS = 4
) (
  input wire logic          i_Clk,
  input wire logic          i_Rst,
  spi_cs_sequencer_if.slave bus
);
  localparam int CW = $clog2(MAX_BYTES_PER_CS + 1);
  localparam int LW = (CS_LEAD_CLKS > 1) ? $clog2(CS_LEAD_CLKS) : 1;
  localparam int GW = (CS_INACTIVE_CLKS > 1) ? $clog2(CS_INACTIVE_CLKS) : 1;

  localparam logic [CW-1:0] c_max       = CW'(MAX_BYTES_PER_CS);
  localparam logic [CW-1:0] c_idx_max   = CW'(MAX_BYTES_PER_CS - 1);
  localparam logic [LW-1:0] c_lead_last = LW'(CS_LEAD_CLKS - 1);
  localparam logic [GW-1:0] c_gap_last  = GW'(CS_INACTIVE_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CS_LEAD   = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_WAIT_BYTE = 3'd4,
    S_CS_GAP    = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic          cs_n_q, cs_n_d;
  logic          tx_ready_q, tx_ready_d;
  logic          m_tx_dv_q, m_tx_dv_d;
  logic [7:0]    m_tx_byte_q, m_tx_byte_d;
  logic [CW-1:0] remaining_q, remaining_d;
  logic [LW-1:0] lead_cnt_q, lead_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          armed_q, armed_d;
  logic          rx_dv_q, rx_dv_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic [CW-1:0] rx_count_q, rx_count_d;
  logic [CW-1:0] rx_idx_q, rx_idx_d;

  logic          w_tx_accept;
  logic          w_burst_start;
  logic [CW-1:0] w_count_clamped;
  logic [CW-1:0] w_idx_base;

  always_comb begin
    state_d       = state_q;
    cs_n_d        = cs_n_q;
    m_tx_dv_d     = 1'b0;
    m_tx_byte_d   = m_tx_byte_q;
    remaining_d   = remaining_q;
    lead_cnt_d    = lead_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    armed_d       = armed_q;
    w_burst_start = 1'b0;
    w_tx_accept   = bus.i_TX_DV && tx_ready_q;

    if (bus.i_TX_Count == '0) begin
      w_count_clamped = CW'(1);
    end else if (bus.i_TX_Count > c_max) begin
      w_count_clamped = c_max;
    end else begin
      w_count_clamped = bus.i_TX_Count;
    end

    case (state_q)
      S_IDLE: begin
        if (w_tx_accept) begin
          m_tx_byte_d   = bus.i_TX_Byte;
          remaining_d   = w_count_clamped;
          cs_n_d        = 1'b0;
          lead_cnt_d    = '0;
          w_burst_start = 1'b1;
          state_d       = S_CS_LEAD;
        end
      end
      S_CS_LEAD: begin
        if (lead_cnt_q == c_lead_last) begin
          state_d = S_ISSUE;
        end else begin
          lead_cnt_d = lead_cnt_q + LW'(1);
        end
      end
      S_ISSUE: begin
        m_tx_dv_d   = 1'b1;
        remaining_d = remaining_q - CW'(1);
        armed_d     = 1'b0;
        state_d     = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // The master still shows ready for a cycle after the DV; wait to see it drop.
        if (!armed_q) begin
          if (!bus.i_M_TX_Ready) armed_d = 1'b1;
        end else if (bus.i_M_TX_Ready) begin
          if (remaining_q != '0) begin
            state_d = S_WAIT_BYTE;
          end else begin
            cs_n_d    = 1'b1;
            gap_cnt_d = '0;
            state_d   = S_CS_GAP;
          end
        end
      end
      S_WAIT_BYTE: begin
        if (w_tx_accept) begin
          m_tx_byte_d = bus.i_TX_Byte;
          state_d     = S_ISSUE;
        end
      end
      S_CS_GAP: begin
        if (gap_cnt_q == c_gap_last) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: begin
        cs_n_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    tx_ready_d = ((state_d == S_IDLE) && bus.i_M_TX_Ready) || (state_d == S_WAIT_BYTE);

    // RX tagging runs regardless of state; a pulse at burst start takes index 0.
    w_idx_base = w_burst_start ? '0 : rx_idx_q;
    rx_dv_d    = bus.i_M_RX_DV;
    rx_byte_d  = rx_byte_q;
    rx_count_d = rx_count_q;
    rx_idx_d   = w_idx_base;
    if (bus.i_M_RX_DV) begin
      rx_byte_d  = bus.i_M_RX_Byte;
      rx_count_d = w_idx_base;
      if (w_idx_base != c_idx_max) rx_idx_d = w_idx_base + CW'(1);
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q     <= S_IDLE;
      cs_n_q      <= 1'b1;
      tx_ready_q  <= 1'b0;
      m_tx_dv_q   <= 1'b0;
      m_tx_byte_q <= '0;
      remaining_q <= '0;
      lead_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      armed_q     <= 1'b0;
      rx_dv_q     <= 1'b0;
      rx_byte_q   <= '0;
      rx_count_q  <= '0;
      rx_idx_q    <= '0;
    end else begin
      state_q     <= state_d;
      cs_n_q      <= cs_n_d;
      tx_ready_q  <= tx_ready_d;
      m_tx_dv_q   <= m_tx_dv_d;
      m_tx_byte_q <= m_tx_byte_d;
      remaining_q <= remaining_d;
      lead_cnt_q  <= lead_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      armed_q     <= armed_d;
      rx_dv_q     <= rx_dv_d;
      rx_byte_q   <= rx_byte_d;
      rx_count_q  <= rx_count_d;
      rx_idx_q    <= rx_idx_d;
    end
  end

  assign bus.o_SPI_CS_n  = cs_n_q;
  assign bus.o_TX_Ready  = tx_ready_q;
  assign bus.o_M_TX_DV   = m_tx_dv_q;
  assign bus.o_M_TX_Byte = m_tx_byte_q;
  assign bus.o_RX_DV     = rx_dv_q;
  assign bus.o_RX_Byte   = rx_byte_q;
  assign bus.o_RX_Count  = rx_count_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_cs_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_spi_cs_sequencer
// Directed bursts against a byte-level SPI master model with one-cycle ready lag.
// Rev    : 1.0
// ============================================================================
module tb_spi_cs_sequencer;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  spi_cs_sequencer_if #(.CW(CW)) bus ();

  spi_cs_sequencer #(
    .MAX_BYTES_PER_CS (4),
    .CS_LEAD_CLKS     (2),
    .CS_INACTIVE_CLKS (4)
  ) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] echo_of(input logic [7:0] b);
    return (b == 8'hA5) ? 8'h3C : {4'hF, b[3:0]};
  endfunction

  // Master model: ready lingers one cycle after DV, RX pulse 3 cycles later, ready after RX.
  logic [7:0] m_byte;
  initial begin
    bus.i_M_TX_Ready = 1'b1;
    bus.i_M_RX_DV    = 1'b0;
    bus.i_M_RX_Byte  = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.o_M_TX_DV === 1'b1) begin
        m_byte = bus.o_M_TX_Byte;
        @(negedge clk);
        bus.i_M_TX_Ready = 1'b0;
        repeat (3) @(negedge clk);
        bus.i_M_RX_DV   = 1'b1;
        bus.i_M_RX_Byte = echo_of(m_byte);
        @(negedge clk);
        bus.i_M_RX_DV    = 1'b0;
        bus.i_M_TX_Ready = 1'b1;
      end
    end
  end

  int         cyc = 0, mtx_n = 0, rx_n = 0, cs_fall_n = 0, cs_rise_n = 0;
  int         cs_fall_cyc = 0, cs_rise_cyc = 0;
  logic [7:0] mtx_b [64];
  int         mtx_c [64];
  logic [7:0] rx_b [64];
  logic [CW-1:0] rx_i [64];
  int         rx_c [64];
  logic       cs_prev = 1'b1;
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.o_M_TX_DV === 1'b1) begin
        mtx_b[mtx_n % 64] = bus.o_M_TX_Byte;
        mtx_c[mtx_n % 64] = cyc;
        mtx_n++;
      end
      if (bus.o_RX_DV === 1'b1) begin
        rx_b[rx_n % 64] = bus.o_RX_Byte;
        rx_i[rx_n % 64] = bus.o_RX_Count;
        rx_c[rx_n % 64] = cyc;
        rx_n++;
      end
      if (cs_prev === 1'b1 && bus.o_SPI_CS_n === 1'b0) begin cs_fall_n++; cs_fall_cyc = cyc; end
      if (cs_prev === 1'b0 && bus.o_SPI_CS_n === 1'b1) begin cs_rise_n++; cs_rise_cyc = cyc; end
      cs_prev = bus.o_SPI_CS_n;
    end
  end

  task automatic host_send(input logic [CW-1:0] cnt, input logic [7:0] b);
    int t = 0;
    while (bus.o_TX_Ready !== 1'b1 && t < 500) begin @(negedge clk); t++; end
    checks++;
    if (bus.o_TX_Ready !== 1'b1) begin
      failures++;
      $display("FAIL host_ready_timeout: o_TX_Ready=%b after %0d cycles, required 1", bus.o_TX_Ready, t);
    end
    bus.i_TX_Count = cnt;
    bus.i_TX_Byte  = b;
    bus.i_TX_DV    = 1'b1;
    @(negedge clk);
    bus.i_TX_DV    = 1'b0;
  endtask

  task automatic wait_cs_high(input string name);
    int t = 0;
    while (bus.o_SPI_CS_n !== 1'b1 && t < 400) begin @(negedge clk); t++; end
    checks++;
    if (bus.o_SPI_CS_n !== 1'b1) begin
      failures++;
      $display("FAIL %s_cs_rise_timeout: cs_n=%b after %0d cycles, required 1", name, bus.o_SPI_CS_n, t);
    end
  endtask

  task automatic test_reset();
    bus.i_TX_Count = '0;
    bus.i_TX_Byte  = 8'h00;
    bus.i_TX_DV    = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.o_SPI_CS_n !== 1'b1) begin failures++; $display("FAIL reset_cs_n: got %b want 1", bus.o_SPI_CS_n); end
    checks++; if (bus.o_TX_Ready !== 1'b0) begin failures++; $display("FAIL reset_tx_ready: got %b want 0", bus.o_TX_Ready); end
    checks++; if (bus.o_M_TX_DV !== 1'b0) begin failures++; $display("FAIL reset_m_tx_dv: got %b want 0", bus.o_M_TX_DV); end
    checks++; if (bus.o_M_TX_Byte !== 8'h00) begin failures++; $display("FAIL reset_m_tx_byte: got %h want 00", bus.o_M_TX_Byte); end
    checks++; if (bus.o_RX_DV !== 1'b0) begin failures++; $display("FAIL reset_rx_dv: got %b want 0", bus.o_RX_DV); end
    checks++; if (bus.o_RX_Byte !== 8'h00) begin failures++; $display("FAIL reset_rx_byte: got %h want 00", bus.o_RX_Byte); end
    checks++; if (bus.o_RX_Count !== 3'd0) begin failures++; $display("FAIL reset_rx_count: got %0d want 0", bus.o_RX_Count); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.o_TX_Ready !== 1'b1) begin failures++; $display("FAIL idle_tx_ready: got %b want 1", bus.o_TX_Ready); end
    checks++; if (bus.o_SPI_CS_n !== 1'b1) begin failures++; $display("FAIL idle_cs_n: got %b want 1", bus.o_SPI_CS_n); end
  endtask

  task automatic test_single();
    int mb, rb;
    #1; mb = mtx_n; rb = rx_n;
    host_send(3'd1, 8'hA5);
    wait_cs_high("single");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.o_TX_Ready !== 1'b0) begin failures++; $display("FAIL single_gap_ready[%0d]: got %b want 0", i, bus.o_TX_Ready); end
      @(negedge clk);
    end
    checks++; if (bus.o_TX_Ready !== 1'b1) begin failures++; $display("FAIL single_ready_after_gap: got %b want 1", bus.o_TX_Ready); end
    #1;
    checks++; if (mtx_n - mb !== 1) begin failures++; $display("FAIL single_mtx_count: got %0d want 1", mtx_n - mb); end
    checks++; if (mtx_b[mb % 64] !== 8'hA5) begin failures++; $display("FAIL single_mtx_byte: got %h want a5", mtx_b[mb % 64]); end
    checks++; if (mtx_c[mb % 64] - cs_fall_cyc !== 3) begin failures++; $display("FAIL single_lead: got %0d want 3", mtx_c[mb % 64] - cs_fall_cyc); end
    checks++; if (rx_n - rb !== 1) begin failures++; $display("FAIL single_rx_count: got %0d want 1", rx_n - rb); end
    checks++; if (rx_b[rb % 64] !== 8'h3C || rx_i[rb % 64] !== 3'd0) begin
      failures++; $display("FAIL single_rx: got %h/%0d want 3c/0", rx_b[rb % 64], rx_i[rb % 64]); end
  endtask

  task automatic test_burst4();
    int mb, rb, fb, cb;
    #1; mb = mtx_n; rb = rx_n; fb = cs_fall_n; cb = cs_rise_n;
    host_send(3'd4, 8'h01);
    for (int k = 2; k <= 4; k++) host_send(3'd1, 8'(k));
    wait_cs_high("burst4");
    #1;
    checks++; if (mtx_n - mb !== 4) begin failures++; $display("FAIL burst4_mtx_count: got %0d want 4", mtx_n - mb); end
    checks++; if (cs_fall_n - fb !== 1 || cs_rise_n - cb !== 1) begin
      failures++; $display("FAIL burst4_cs_edges: falls=%0d rises=%0d want 1/1", cs_fall_n - fb, cs_rise_n - cb); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (mtx_b[(mb + k) % 64] !== 8'(k + 1) || rx_b[(rb + k) % 64] !== 8'(8'hF1 + k) || rx_i[(rb + k) % 64] !== 3'(k)) begin
        failures++;
        $display("FAIL burst4_byte[%0d]: tx=%h rx=%h idx=%0d want %h/%h/%0d", k, mtx_b[(mb + k) % 64],
                 rx_b[(rb + k) % 64], rx_i[(rb + k) % 64], 8'(k + 1), 8'(8'hF1 + k), k);
      end
    end
  endtask

  task automatic test_host_stall();
    int mb, rb, fb, t, bad;
    #1; mb = mtx_n; rb = rx_n; fb = cs_fall_n;
    host_send(3'd2, 8'h11);
    t = 0;
    while (bus.o_TX_Ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus.o_TX_Ready !== 1'b1 || bus.o_SPI_CS_n !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL stall_hold: %0d cycles without ready=1/cs_n=0, want 0", bad); end
    #1;
    checks++; if (mtx_n - mb !== 1) begin failures++; $display("FAIL stall_mtx_during: got %0d want 1", mtx_n - mb); end
    host_send(3'd3, 8'h22);
    wait_cs_high("stall");
    #1;
    checks++; if (mtx_n - mb !== 2 || mtx_b[(mb + 1) % 64] !== 8'h22) begin
      failures++; $display("FAIL stall_mtx_total: got %0d/%h want 2/22", mtx_n - mb, mtx_b[(mb + 1) % 64]); end
    checks++; if (rx_n - rb !== 2 || rx_i[(rb + 1) % 64] !== 3'd1 || rx_b[(rb + 1) % 64] !== 8'hF2) begin
      failures++; $display("FAIL stall_rx: got n=%0d idx=%0d byte=%h want 2/1/f2", rx_n - rb, rx_i[(rb + 1) % 64], rx_b[(rb + 1) % 64]); end
    checks++; if (cs_fall_n - fb !== 1) begin failures++; $display("FAIL stall_cs_falls: got %0d want 1", cs_fall_n - fb); end
  endtask

  task automatic test_ready_lag();
    int mb, rb;
    #1; mb = mtx_n; rb = rx_n;
    host_send(3'd1, 8'h5A);
    wait_cs_high("lag");
    #1;
    checks++; if (rx_n - rb !== 1 || rx_b[rb % 64] !== 8'hFA) begin
      failures++; $display("FAIL lag_rx: got n=%0d byte=%h want 1/fa", rx_n - rb, rx_b[rb % 64]); end
    checks++; if (!(rx_c[rb % 64] < cs_rise_cyc)) begin
      failures++; $display("FAIL lag_rx_before_cs: rx at %0d cs rise at %0d, want rx earlier", rx_c[rb % 64], cs_rise_cyc); end
    checks++; if (cs_rise_cyc - mtx_c[mb % 64] !== 6) begin
      failures++; $display("FAIL lag_cs_rise_delay: got %0d want 6", cs_rise_cyc - mtx_c[mb % 64]); end
  endtask

  task automatic test_count_zero();
    int mb, rb;
    #1; mb = mtx_n; rb = rx_n;
    host_send(3'd0, 8'h77);
    wait_cs_high("count0");
    repeat (6) @(negedge clk);
    #1;
    checks++; if (mtx_n - mb !== 1) begin failures++; $display("FAIL count0_mtx: got %0d want 1", mtx_n - mb); end
    checks++; if (rx_b[rb % 64] !== 8'hF7 || rx_i[rb % 64] !== 3'd0) begin
      failures++; $display("FAIL count0_rx: got %h/%0d want f7/0", rx_b[rb % 64], rx_i[rb % 64]); end
  endtask

  task automatic test_count_clamp();
    int mb, rb, fb;
    #1; mb = mtx_n; rb = rx_n; fb = cs_fall_n;
    host_send(3'd7, 8'h81);
    for (int k = 2; k <= 4; k++) host_send(3'd7, 8'(8'h80 + k));
    wait_cs_high("clamp");
    repeat (6) @(negedge clk);
    #1;
    checks++; if (mtx_n - mb !== 4) begin failures++; $display("FAIL clamp_mtx: got %0d want 4", mtx_n - mb); end
    checks++; if (rx_i[(rb + 3) % 64] !== 3'd3 || rx_b[(rb + 3) % 64] !== 8'hF4) begin
      failures++; $display("FAIL clamp_last_rx: got %h/%0d want f4/3", rx_b[(rb + 3) % 64], rx_i[(rb + 3) % 64]); end
    checks++; if (cs_fall_n - fb !== 1) begin failures++; $display("FAIL clamp_cs_falls: got %0d want 1", cs_fall_n - fb); end
  endtask

  task automatic test_gap_ignore();
    int mb, fb;
    host_send(3'd1, 8'h66);
    wait_cs_high("gap");
    #1; mb = mtx_n; fb = cs_fall_n;
    @(negedge clk);
    checks++; if (bus.o_TX_Ready !== 1'b0) begin failures++; $display("FAIL gap_ready: got %b want 0", bus.o_TX_Ready); end
    bus.i_TX_Count = 3'd1;
    bus.i_TX_Byte  = 8'hEE;
    bus.i_TX_DV    = 1'b1;
    @(negedge clk);
    bus.i_TX_DV    = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    checks++; if (mtx_n - mb !== 0) begin failures++; $display("FAIL gap_mtx: got %0d want 0", mtx_n - mb); end
    checks++; if (cs_fall_n - fb !== 0 || bus.o_SPI_CS_n !== 1'b1) begin
      failures++; $display("FAIL gap_cs: falls=%0d cs_n=%b want 0/1", cs_fall_n - fb, bus.o_SPI_CS_n); end
  endtask

  task automatic test_reset_mid_burst();
    int mb, rb, t;
    host_send(3'd3, 8'h31);
    host_send(3'd3, 8'h32);
    t = 0;
    while (bus.o_M_TX_DV !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    checks++; if (bus.o_M_TX_DV !== 1'b1) begin failures++; $display("FAIL midrst_second_dv: got %b want 1", bus.o_M_TX_DV); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.o_SPI_CS_n !== 1'b1) begin failures++; $display("FAIL midrst_cs_n: got %b want 1", bus.o_SPI_CS_n); end
    checks++; if (bus.o_TX_Ready !== 1'b0 || bus.o_M_TX_DV !== 1'b0 || bus.o_M_TX_Byte !== 8'h00) begin
      failures++; $display("FAIL midrst_tx_side: ready=%b dv=%b byte=%h want 0/0/00", bus.o_TX_Ready, bus.o_M_TX_DV, bus.o_M_TX_Byte); end
    checks++; if (bus.o_RX_DV !== 1'b0 || bus.o_RX_Byte !== 8'h00 || bus.o_RX_Count !== 3'd0) begin
      failures++; $display("FAIL midrst_rx_side: dv=%b byte=%h cnt=%0d want 0/00/0", bus.o_RX_DV, bus.o_RX_Byte, bus.o_RX_Count); end
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    #1; mb = mtx_n; rb = rx_n;
    host_send(3'd1, 8'h45);
    wait_cs_high("midrst_after");
    #1;
    checks++; if (mtx_n - mb !== 1 || mtx_b[mb % 64] !== 8'h45) begin
      failures++; $display("FAIL midrst_after_mtx: got %0d/%h want 1/45", mtx_n - mb, mtx_b[mb % 64]); end
    checks++; if (rx_n - rb !== 1 || rx_b[rb % 64] !== 8'hF5 || rx_i[rb % 64] !== 3'd0) begin
      failures++; $display("FAIL midrst_after_rx: got n=%0d %h/%0d want 1/f5/0", rx_n - rb, rx_b[rb % 64], rx_i[rb % 64]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst4();
    test_host_stall();
    test_ready_lag();
    test_count_zero();
    test_count_clamp();
    test_gap_ignore();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
